// File: rtl/filter_win_ctrl.sv
`default_nettype none
// ============================================================================
// filter_win_ctrl : measures edges of the filtered square wave over a gate
// and derives the filter window length as WIN_K / edges (clamped).
// Revision 1.0
// ============================================================================
module filter_win_ctrl #(
    parameter int unsigned GATE_CYC = 10_000_000,
    parameter int unsigned WIN_K    = 200_000,
    parameter int unsigned WIN_MAX  = 20_000,
    parameter int unsigned WIN_INIT = 0
) (
    input  logic        clk_100M,
    input  logic        rst_n,
    input  logic        en,
    input  logic        manual_en,
    input  logic [31:0] manual_win,
    input  logic        sq_sig_filter,
    output logic [31:0] win_len,
    output logic        win_upd,
    output logic        busy,
    output logic [31:0] edge_cnt
);
    localparam logic [31:0] C_GATE_LAST = 32'(GATE_CYC - 1);
    localparam logic [31:0] C_WIN_K     = 32'(WIN_K);
    localparam logic [31:0] C_WIN_MAX   = 32'(WIN_MAX);
    localparam logic [31:0] C_WIN_INIT  = 32'(WIN_INIT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GATE = 2'd1,
        S_DIV  = 2'd2,
        S_UPD  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] gate_cnt_q, gate_cnt_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [4:0]  bit_q, bit_d;
    logic [31:0] win_len_q, win_len_d;
    logic        win_upd_q, win_upd_d;
    logic [31:0] edge_cnt_q, edge_cnt_d;
    logic        prev_q;

    logic        w_rise;
    logic [32:0] w_rem_sh;
    logic        w_take;
    logic [31:0] w_quo_nxt;
    logic [31:0] w_quo_fin;
    logic [31:0] w_acc_inc;

    assign w_rise    = sq_sig_filter & ~prev_q;
    // Restoring division: the accumulator is stable during DIV and acts as divisor.
    assign w_rem_sh  = {rem_q, quo_q[31]};
    assign w_take    = (w_rem_sh >= {1'b0, acc_q});
    assign w_quo_nxt = {quo_q[30:0], w_take};
    assign w_quo_fin = (acc_q == 32'd0)        ? 32'd0     :
                       (w_quo_nxt > C_WIN_MAX) ? C_WIN_MAX : w_quo_nxt;
    assign w_acc_inc = (acc_q == 32'hFFFF_FFFF) ? acc_q : acc_q + 32'd1;

    always_comb begin
        state_d    = state_q;
        gate_cnt_d = gate_cnt_q;
        acc_d      = acc_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        bit_d      = bit_q;
        win_len_d  = win_len_q;
        win_upd_d  = 1'b0;
        edge_cnt_d = edge_cnt_q;
        if (manual_en) begin
            state_d   = S_IDLE;
            win_len_d = manual_win;
        end else if (!en) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_UPD: begin
                    state_d    = S_GATE;
                    gate_cnt_d = 32'd0;
                    acc_d      = 32'd0;
                end
                S_GATE: begin
                    if (w_rise) begin
                        acc_d = w_acc_inc;
                    end
                    if (gate_cnt_q == C_GATE_LAST) begin
                        state_d = S_DIV;
                        rem_d   = 32'd0;
                        quo_d   = C_WIN_K;
                        bit_d   = 5'd0;
                    end else begin
                        gate_cnt_d = gate_cnt_q + 32'd1;
                    end
                end
                S_DIV: begin
                    rem_d = w_take ? 32'(w_rem_sh - {1'b0, acc_q}) : w_rem_sh[31:0];
                    quo_d = w_quo_nxt;
                    bit_d = bit_q + 5'd1;
                    // Last quotient bit resolves on the same edge that loads the outputs.
                    if (bit_q == 5'd31) begin
                        state_d    = S_UPD;
                        win_len_d  = w_quo_fin;
                        edge_cnt_d = acc_q;
                        win_upd_d  = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_100M) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            gate_cnt_q <= 32'd0;
            acc_q      <= 32'd0;
            rem_q      <= 32'd0;
            quo_q      <= 32'd0;
            bit_q      <= 5'd0;
            win_len_q  <= C_WIN_INIT;
            win_upd_q  <= 1'b0;
            edge_cnt_q <= 32'd0;
            prev_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gate_cnt_q <= gate_cnt_d;
            acc_q      <= acc_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            bit_q      <= bit_d;
            win_len_q  <= win_len_d;
            win_upd_q  <= win_upd_d;
            edge_cnt_q <= edge_cnt_d;
            prev_q     <= sq_sig_filter;
        end
    end

    assign win_len  = win_len_q;
    assign win_upd  = win_upd_q;
    assign edge_cnt = edge_cnt_q;
    assign busy     = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_filter_win_ctrl.sv
`default_nettype none
// ============================================================================
// tb_filter_win_ctrl : scoreboard bench for filter_win_ctrl with a short gate.
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_filter_win_ctrl;
    logic        clk_100M      = 1'b0;
    logic        rst_n         = 1'b0;
    logic        en            = 1'b0;
    logic        manual_en     = 1'b0;
    logic [31:0] manual_win    = 32'd0;
    logic        sq_sig_filter = 1'b0;
    logic [31:0] win_len;
    logic        win_upd;
    logic        busy;
    logic [31:0] edge_cnt;

    always #5 clk_100M = ~clk_100M;

    filter_win_ctrl #(
        .GATE_CYC (1000),
        .WIN_K    (2000),
        .WIN_MAX  (500),
        .WIN_INIT (0)
    ) dut (
        .clk_100M      (clk_100M),
        .rst_n         (rst_n),
        .en            (en),
        .manual_en     (manual_en),
        .manual_win    (manual_win),
        .sq_sig_filter (sq_sig_filter),
        .win_len       (win_len),
        .win_upd       (win_upd),
        .busy          (busy),
        .edge_cnt      (edge_cnt)
    );

    int cyc = 0;
    always @(posedge clk_100M) cyc <= cyc + 1;

    // Square-wave source: period sq_per cycles, 50% duty; 0 holds the line low.
    int sq_per = 0;
    int ph     = 0;
    always @(posedge clk_100M) begin
        #1;
        if (sq_per == 0) begin
            sq_sig_filter = 1'b0;
            ph = 0;
        end else begin
            ph = (ph + 1) % sq_per;
            sq_sig_filter = (ph < sq_per / 2);
        end
    end

    typedef struct {
        int          cyc;
        logic [31:0] win;
        logic [31:0] ec;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(negedge clk_100M) begin
        if (win_upd === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_win_upd: got pulse at cycle %0d expected none", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("upd_cycle", 32'(cyc), 32'(mon_e.cyc));
                chk("upd_win_len", win_len, mon_e.win);
                chk("upd_edge_cnt", edge_cnt, mon_e.ec);
            end
        end
    end

    initial begin
        int n;
        repeat (3) @(posedge clk_100M);
        @(negedge clk_100M);
        chk("rst_win_len", win_len, 32'd0);
        chk("rst_edge_cnt", edge_cnt, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_win_upd", {31'd0, win_upd}, 32'd0);
        @(posedge clk_100M); #1 rst_n = 1'b1;

        // Period 100: 10 edges -> 200; second result one UPD later
        sq_per = 100;
        repeat (20) @(posedge clk_100M);
        #1 en = 1'b1; n = cyc;
        sb.push_back('{n + 1033, 32'd200, 32'd10});
        sb.push_back('{n + 2066, 32'd200, 32'd10});
        @(posedge clk_100M); @(negedge clk_100M);
        chk("busy_in_gate", {31'd0, busy}, 32'd1);
        repeat (2074) @(posedge clk_100M);
        #1 en = 1'b0;
        @(posedge clk_100M); @(negedge clk_100M);
        chk("idle_after_en_low", {31'd0, busy}, 32'd0);
        chk("hold_win_len", win_len, 32'd200);

        // Period 500: 2 edges -> 1000 clamped to 500
        sq_per = 500; ph = 0;
        repeat (20) @(posedge clk_100M);
        #1 en = 1'b1; n = cyc;
        sb.push_back('{n + 1033, 32'd500, 32'd2});
        repeat (1040) @(posedge clk_100M);
        #1 en = 1'b0;

        // No edges -> bypass window 0
        sq_per = 0;
        repeat (5) @(posedge clk_100M);
        #1 en = 1'b1; n = cyc;
        sb.push_back('{n + 1033, 32'd0, 32'd0});
        repeat (1040) @(posedge clk_100M);
        #1 en = 1'b0;

        // Manual override mid-gate, then release with en still high
        sq_per = 100;
        repeat (5) @(posedge clk_100M);
        #1 en = 1'b1;
        repeat (300) @(posedge clk_100M);
        @(negedge clk_100M);
        chk("busy_mid_gate", {31'd0, busy}, 32'd1);
        @(posedge clk_100M); #1 manual_en = 1'b1; manual_win = 32'd77;
        @(posedge clk_100M); @(negedge clk_100M);
        chk("manual_win_77", win_len, 32'd77);
        chk("manual_busy", {31'd0, busy}, 32'd0);
        @(posedge clk_100M); #1 manual_win = 32'd123;
        @(posedge clk_100M); @(negedge clk_100M);
        chk("manual_win_123", win_len, 32'd123);
        @(posedge clk_100M); #1 manual_en = 1'b0; n = cyc;
        sb.push_back('{n + 1033, 32'd200, 32'd10});
        repeat (500) @(posedge clk_100M);
        @(negedge clk_100M);
        chk("manual_hold", win_len, 32'd123);
        repeat (540) @(posedge clk_100M);
        #1 en = 1'b0;

        // Drop en at gate cycle 500, then a full restart gate with period 200
        sq_per = 200; ph = 0;
        repeat (5) @(posedge clk_100M);
        #1 en = 1'b1;
        repeat (500) @(posedge clk_100M);
        #1 en = 1'b0;
        @(posedge clk_100M); @(negedge clk_100M);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_win_len", win_len, 32'd200);
        repeat (10) @(posedge clk_100M);
        #1 en = 1'b1; n = cyc;
        sb.push_back('{n + 1033, 32'd400, 32'd5});
        repeat (1040) @(posedge clk_100M);
        #1 en = 1'b0;

        // Reset during DIV cycle 10
        sq_per = 100;
        repeat (5) @(posedge clk_100M);
        #1 en = 1'b1;
        repeat (1010) @(posedge clk_100M);
        #1 rst_n = 1'b0; en = 1'b0;
        @(posedge clk_100M); @(negedge clk_100M);
        chk("divrst_win_len", win_len, 32'd0);
        chk("divrst_edge_cnt", edge_cnt, 32'd0);
        chk("divrst_busy", {31'd0, busy}, 32'd0);
        chk("divrst_win_upd", {31'd0, win_upd}, 32'd0);
        @(posedge clk_100M); #1 rst_n = 1'b1;
        repeat (60) @(posedge clk_100M);
        @(negedge clk_100M);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
